// File: rtl/stopwatch_lap.sv
// N-digit BCD stopwatch with a tick prescaler, run/pause/clear control,
// lap-freeze display, sticky overflow and registered seven-segment outputs.

module stopwatch_lap_seg (
   input  logic [3:0] digit,
   input  logic       dp,
   output logic [7:0] seg
);
   always_comb begin
      seg[7] = ~dp;
      case (digit)
         4'd0:    seg[6:0] = 7'h40;
         4'd1:    seg[6:0] = 7'h79;
         4'd2:    seg[6:0] = 7'h24;
         4'd3:    seg[6:0] = 7'h30;
         4'd4:    seg[6:0] = 7'h19;
         4'd5:    seg[6:0] = 7'h12;
         4'd6:    seg[6:0] = 7'h02;
         4'd7:    seg[6:0] = 7'h78;
         4'd8:    seg[6:0] = 7'h00;
         4'd9:    seg[6:0] = 7'h10;
         default: seg[6:0] = 7'h7F;
      endcase
   end
endmodule

module stopwatch_lap #(
   parameter int NUM_DIGITS = 3,
   parameter int CLK_DIV    = 500000,
   parameter int DP_POS     = 1
) (
   input  logic                    Clk,
   input  logic                    nReset,
   input  logic                    StartStop,
   input  logic                    Lap,
   input  logic                    Clear,
   output logic [8*NUM_DIGITS-1:0] SSeg,
   output logic                    Running,
   output logic                    LapActive,
   output logic                    Overflow
);
   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   function automatic logic [8*NUM_DIGITS-1:0] seg_zero();
      logic [8*NUM_DIGITS-1:0] v;
      for (int i = 0; i < NUM_DIGITS; i++)
         v[8*i +: 8] = (i == DP_POS) ? 8'h40 : 8'hC0;
      return v;
   endfunction

   localparam logic [8*NUM_DIGITS-1:0] SEG_RST = seg_zero();

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t                        state_q, state_d;
   logic [PW-1:0]                 presc;
   logic [NUM_DIGITS-1:0][3:0]    cnt, lap_q, src;
   logic [NUM_DIGITS:0]           carry;
   logic [8*NUM_DIGITS-1:0]       seg_d;
   logic                          tick, lap_cap, lap_rel;

   always_comb begin
      state_d = state_q;
      if (Clear)
         state_d = IDLE;
      else if (StartStop)
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
   end

   always_ff @(posedge Clk or negedge nReset)
      if (!nReset) state_q <= IDLE;
      else         state_q <= state_d;

   assign Running = (state_q == RUN);
   assign tick    = Running && !Clear && (presc == PW'(CLK_DIV - 1));

   always_ff @(posedge Clk or negedge nReset)
      if (!nReset)      presc <= '0;
      else if (Clear)   presc <= '0;
      else if (Running) presc <= tick ? '0 : presc + PW'(1);

   // Digit i advances when every lower digit is about to wrap.
   always_comb begin
      carry[0] = tick;
      for (int i = 0; i < NUM_DIGITS; i++)
         carry[i+1] = carry[i] && (cnt[i] == 4'd9);
   end

   always_ff @(posedge Clk or negedge nReset)
      if (!nReset)
         cnt <= '0;
      else if (Clear)
         cnt <= '0;
      else
         for (int i = 0; i < NUM_DIGITS; i++)
            if (carry[i]) cnt[i] <= (cnt[i] == 4'd9) ? 4'd0 : cnt[i] + 4'd1;

   always_ff @(posedge Clk or negedge nReset)
      if (!nReset)                   Overflow <= 1'b0;
      else if (Clear)                Overflow <= 1'b0;
      else if (carry[NUM_DIGITS])    Overflow <= 1'b1;

   // The capture takes the pre-tick count of the same cycle.
   assign lap_cap = Lap && !Clear && Running && !LapActive;
   assign lap_rel = Lap && !Clear && LapActive && (state_q != IDLE);

   always_ff @(posedge Clk or negedge nReset)
      if (!nReset) begin
         lap_q     <= '0;
         LapActive <= 1'b0;
      end else if (Clear) begin
         lap_q     <= '0;
         LapActive <= 1'b0;
      end else if (lap_cap) begin
         lap_q     <= cnt;
         LapActive <= 1'b1;
      end else if (lap_rel) begin
         LapActive <= 1'b0;
      end

   assign src = LapActive ? lap_q : cnt;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
      stopwatch_lap_seg u_seg (
         .digit (src[i]),
         .dp    (i == DP_POS),
         .seg   (seg_d[8*i +: 8])
      );
   end

   always_ff @(posedge Clk or negedge nReset)
      if (!nReset) SSeg <= SEG_RST;
      else         SSeg <= seg_d;
endmodule
